// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Elastic valid/ready pipeline register with optional 2-entry skid.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int unsigned WIDTH         = 64,
  parameter bit          SKID          = 1'b1,
  parameter bit          CLEAR_PAYLOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_skid_q;
  logic [WIDTH-1:0] w_main_d;

  // State encoding equals the entry count, so occupancy is the state itself.
  assign out_valid_o = (r_state != S_EMPTY);
  assign occupancy_o = r_state;
  assign out_data_o  = r_main;
  assign in_ready_o  = w_in_ready;
  assign w_in_fire   = in_valid_i & w_in_ready;
  assign w_out_fire  = out_valid_o & out_ready_i;
  assign w_main_d    = (r_state == S_FULL) ? w_skid_q : in_data_i;

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = S_ONE;
            w_main_en   = 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_fire) begin
            w_state_nxt = w_out_fire ? S_ONE : S_FULL;
            w_main_en   = w_out_fire;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = S_ONE;
            w_main_en   = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  if (SKID) begin : g_skid
    logic             r_in_ready;
    logic             w_skid_en;
    logic [WIDTH-1:0] r_skid;

    // Second entry is only written when the head stays put and a new one arrives.
    assign w_skid_en = !flush_i & w_in_fire & !w_out_fire & (r_state == S_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_in_ready <= 1'b1;
      end else begin
        r_in_ready <= (w_state_nxt != S_FULL);
      end
    end

    if (CLEAR_PAYLOAD) begin : g_skid_clr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_skid <= '0;
        end else if (flush_i) begin
          r_skid <= '0;
        end else if (w_skid_en) begin
          r_skid <= in_data_i;
        end
      end
    end else begin : g_skid_hold
      always_ff @(posedge clk) begin
        if (w_skid_en) begin
          r_skid <= in_data_i;
        end
      end
    end

    assign w_in_ready = r_in_ready;
    assign w_skid_q   = r_skid;
  end else begin : g_noskid
    assign w_in_ready = !out_valid_o | out_ready_i;
    assign w_skid_q   = '0;
  end

  if (CLEAR_PAYLOAD) begin : g_main_clr
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_main <= '0;
      end else if (flush_i) begin
        r_main <= '0;
      end else if (w_main_en) begin
        r_main <= w_main_d;
      end
    end
  end else begin : g_main_hold
    always_ff @(posedge clk) begin
      if (w_main_en) begin
        r_main <= w_main_d;
      end
    end
  end

endmodule
`default_nettype wire
